// File: rtl/dice_pkg.sv
// Shared types and constants for the dice scorer: FSM state encoding
// and active-low seven-segment glyphs ({g,f,e,d,c,b,a}, 0 = lit).
package dice_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational decode of a 3-bit dice value to an active-low
// seven-segment pattern. Values 0 and 7 show a dash; blank_i wins.
module seg7_decoder
    import dice_pkg::*;
(
    input  logic [2:0] value_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Glyph lookup, blank overrides the value
    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (value_i)
                3'd1:    seg_o = SEG_1;
                3'd2:    seg_o = SEG_2;
                3'd3:    seg_o = SEG_3;
                3'd4:    seg_o = SEG_4;
                3'd5:    seg_o = SEG_5;
                3'd6:    seg_o = SEG_6;
                default: seg_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/dice_scorer.sv
// Dice scorer: detects a qualified button press/release, captures the
// settled dice throw one cycle after release, and keeps score, throw
// count, double detection and a sticky illegal-throw flag per game.
module dice_scorer
    import dice_pkg::*;
#(
    parameter int MAX_THROWS = 8,
    parameter int MIN_PRESS  = 2,
    parameter int SCORE_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button,
    input  logic [2:0]         throw,
    input  logic               new_game,
    output logic [2:0]         result,
    output logic               result_valid,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         throw_count,
    output logic               double_flag,
    output logic               game_over,
    output logic               err,
    output logic [6:0]         seg
);

    localparam int PW = (MIN_PRESS < 2) ? 1 : $clog2(MIN_PRESS + 1);
    localparam logic [PW-1:0] PRESS_SAT = PW'(MIN_PRESS);
    localparam logic [3:0]    MAX_CNT   = 4'(MAX_THROWS);

    state_t             state_q, state_d;
    logic [PW-1:0]      press_cnt_q, press_cnt_d;
    logic [2:0]         result_q, result_d;
    logic               valid_q, valid_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         count_q, count_d;
    logic               double_q, double_d;
    logic               over_q, over_d;
    logic               err_q, err_d;
    logic [2:0]         prev_q, prev_d;
    // Set on any capture; the display stays blank until the first one.
    logic               captured_q, captured_d;
    logic [6:0]         seg_q, seg_d;
    logic               throw_legal;

    assign throw_legal = (throw != 3'd0) && (throw != 3'd7);

    // Next-state and datapath update; new_game overrides the FSM
    always_comb begin
        state_d     = state_q;
        press_cnt_d = press_cnt_q;
        result_d    = result_q;
        valid_d     = 1'b0;
        score_d     = score_q;
        count_d     = count_q;
        double_d    = double_q;
        err_d       = err_q;
        prev_d      = prev_q;
        captured_d  = captured_q;

        if (new_game) begin
            state_d     = ST_IDLE;
            press_cnt_d = '0;
            result_d    = 3'd0;
            score_d     = '0;
            count_d     = 4'd0;
            double_d    = 1'b0;
            err_d       = 1'b0;
            prev_d      = 3'd0;
            captured_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (button) begin
                        state_d     = ST_PRESSED;
                        press_cnt_d = PW'(1);
                    end
                end
                ST_PRESSED: begin
                    if (button) begin
                        if (press_cnt_q < PRESS_SAT) begin
                            press_cnt_d = press_cnt_q + PW'(1);
                        end
                    end else if (press_cnt_q >= PRESS_SAT) begin
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    result_d   = throw;
                    valid_d    = 1'b1;
                    captured_d = 1'b1;
                    if (throw_legal) begin
                        score_d  = score_q + SCORE_W'(throw);
                        count_d  = count_q + 4'd1;
                        double_d = (count_q != 4'd0) && (throw == prev_q);
                        prev_d   = throw;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = (count_d == MAX_CNT) ? ST_DONE : ST_IDLE;
                end
                default: begin
                    state_d = ST_DONE;
                end
            endcase
        end
    end

    assign over_d = (state_d == ST_DONE);

    // Display is decoded from next-state values so it updates with result
    seg7_decoder u_seg7 (
        .value_i (result_d),
        .blank_i (!captured_d),
        .seg_o   (seg_d)
    );

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            press_cnt_q <= '0;
            result_q    <= 3'd0;
            valid_q     <= 1'b0;
            score_q     <= '0;
            count_q     <= 4'd0;
            double_q    <= 1'b0;
            over_q      <= 1'b0;
            err_q       <= 1'b0;
            prev_q      <= 3'd0;
            captured_q  <= 1'b0;
            seg_q       <= SEG_BLANK;
        end else begin
            state_q     <= state_d;
            press_cnt_q <= press_cnt_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            score_q     <= score_d;
            count_q     <= count_d;
            double_q    <= double_d;
            over_q      <= over_d;
            err_q       <= err_d;
            prev_q      <= prev_d;
            captured_q  <= captured_d;
            seg_q       <= seg_d;
        end
    end

    assign result       = result_q;
    assign result_valid = valid_q;
    assign score        = score_q;
    assign throw_count  = count_q;
    assign double_flag  = double_q;
    assign game_over    = over_q;
    assign err          = err_q;
    assign seg          = seg_q;

endmodule

// File: tb/tb_dice_scorer.sv
// Table-driven bench for dice_scorer. Each table row is an operation
// (roll, clear, clear during settle, reset mid-press) plus the state
// expected afterwards; rolls that should capture push an expected
// record to a scoreboard queue that is popped when result_valid pulses.
module tb_dice_scorer;

    localparam int MAX_THROWS = 8;
    localparam int MIN_PRESS  = 2;
    localparam int SCORE_W    = 6;

    typedef enum int {OP_ROLL, OP_NG, OP_NG_SETTLE, OP_RST_PRESS} op_t;

    typedef struct {
        op_t op;
        int  len;
        int  thr;
        bit  cap;
        int  res;
        int  score;
        int  cnt;
        int  dbl;
        int  err;
        int  go;
        int  seg;
    } vec_t;

    typedef struct {
        int res;
        int score;
        int cnt;
        int dbl;
        int err;
        int go;
        int seg;
        int cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               button = 1'b0;
    logic [2:0]         throw = 3'd0;
    logic               new_game = 1'b0;
    logic [2:0]         result;
    logic               result_valid;
    logic [SCORE_W-1:0] score;
    logic [3:0]         throw_count;
    logic               double_flag;
    logic               game_over;
    logic               err;
    logic [6:0]         seg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    vec_t tbl[$];
    exp_t exp_q[$];

    dice_scorer #(
        .MAX_THROWS (MAX_THROWS),
        .MIN_PRESS  (MIN_PRESS),
        .SCORE_W    (SCORE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .button       (button),
        .throw        (throw),
        .new_game     (new_game),
        .result       (result),
        .result_valid (result_valid),
        .score        (score),
        .throw_count  (throw_count),
        .double_flag  (double_flag),
        .game_over    (game_over),
        .err          (err),
        .seg          (seg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: poll result_valid mid-cycle, then land just after the next edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("cap_cycle",  cyc, e.cyc);
                chk("cap_result", int'(result), e.res);
                chk("cap_score",  int'(score), e.score);
                chk("cap_count",  int'(throw_count), e.cnt);
                chk("cap_double", int'(double_flag), e.dbl);
                chk("cap_err",    int'(err), e.err);
                chk("cap_over",   int'(game_over), e.go);
                chk("cap_seg",    int'(seg), e.seg);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input vec_t v);
        chk({tag, "_valid"},  int'(result_valid), 0);
        chk({tag, "_result"}, int'(result), v.res);
        chk({tag, "_score"},  int'(score), v.score);
        chk({tag, "_count"},  int'(throw_count), v.cnt);
        chk({tag, "_double"}, int'(double_flag), v.dbl);
        chk({tag, "_err"},    int'(err), v.err);
        chk({tag, "_over"},   int'(game_over), v.go);
        chk({tag, "_seg"},    int'(seg), v.seg);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic add(input op_t op, input int len, input int thr, input bit cap,
                       input int res, input int sc, input int cnt, input int dbl,
                       input int er, input int go, input int sg);
        vec_t v;
        v.op = op; v.len = len; v.thr = thr; v.cap = cap; v.res = res;
        v.score = sc; v.cnt = cnt; v.dbl = dbl; v.err = er; v.go = go; v.seg = sg;
        tbl.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        case (v.op)
            OP_ROLL: begin
                button = 1'b1;
                repeat (v.len) tick();
                button = 1'b0;
                throw  = 3'(v.thr);
                if (v.cap) begin
                    e.res = v.res; e.score = v.score; e.cnt = v.cnt; e.dbl = v.dbl;
                    e.err = v.err; e.go = v.go; e.seg = v.seg; e.cyc = cyc + 2;
                    exp_q.push_back(e);
                end
                repeat (4) tick();
            end
            OP_NG: begin
                new_game = 1'b1;
                tick();
                new_game = 1'b0;
                repeat (2) tick();
            end
            OP_NG_SETTLE: begin
                button = 1'b1;
                repeat (v.len) tick();
                button = 1'b0;
                throw  = 3'(v.thr);
                tick();
                new_game = 1'b1;
                tick();
                new_game = 1'b0;
                repeat (3) tick();
            end
            default: begin
                button = 1'b1;
                repeat (v.len) tick();
                rst = 1'b1;
                tick();
                rst    = 1'b0;
                button = 1'b0;
                repeat (3) tick();
            end
        endcase
        check_state("post", v);
    endtask

    initial begin
        vec_t rv;

        // Basic capture, short press, exact-minimum press, doubles, illegal throws
        add(OP_ROLL, 5, 4, 1, 4,  4, 1, 0, 0, 0, 'h19);
        add(OP_ROLL, 1, 3, 0, 4,  4, 1, 0, 0, 0, 'h19);
        add(OP_ROLL, 2, 3, 1, 3,  7, 2, 0, 0, 0, 'h30);
        add(OP_ROLL, 3, 3, 1, 3, 10, 3, 1, 0, 0, 'h30);
        add(OP_ROLL, 2, 5, 1, 5, 15, 4, 0, 0, 0, 'h12);
        add(OP_ROLL, 4, 7, 1, 7, 15, 4, 0, 1, 0, 'h3F);
        add(OP_ROLL, 2, 5, 1, 5, 20, 5, 1, 1, 0, 'h12);
        add(OP_ROLL, 2, 0, 1, 0, 20, 5, 1, 1, 0, 'h3F);
        add(OP_NG,   0, 0, 0, 0,  0, 0, 0, 0, 0, 'h7F);
        // Full game of sixes, then a press while DONE is ignored
        for (int i = 1; i <= MAX_THROWS; i++)
            add(OP_ROLL, 2, 6, 1, 6, 6 * i, i, (i > 1) ? 1 : 0, 0,
                (i == MAX_THROWS) ? 1 : 0, 'h02);
        add(OP_ROLL, 3, 2, 0, 6, 48, 8, 1, 0, 1, 'h02);
        add(OP_NG,   0, 0, 0, 0,  0, 0, 0, 0, 0, 'h7F);
        // Clear during SETTLE, then recovery; reset mid-press, then recovery
        add(OP_ROLL, 2, 3, 1, 3,  3, 1, 0, 0, 0, 'h30);
        add(OP_NG_SETTLE, 3, 2, 0, 0, 0, 0, 0, 0, 0, 'h7F);
        add(OP_ROLL, 2, 2, 1, 2,  2, 1, 0, 0, 0, 'h24);
        add(OP_RST_PRESS, 2, 0, 0, 0, 0, 0, 0, 0, 0, 'h7F);
        add(OP_ROLL, 2, 6, 1, 6,  6, 1, 0, 0, 0, 'h02);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        rv.op = OP_NG; rv.len = 0; rv.thr = 0; rv.cap = 0; rv.res = 0; rv.score = 0;
        rv.cnt = 0; rv.dbl = 0; rv.err = 0; rv.go = 0; rv.seg = 'h7F;
        check_state("reset", rv);

        for (int i = 0; i < tbl.size(); i++) begin
            $display("vec %0d: op=%0d len=%0d throw=%0d capture=%0d score=%0d count=%0d",
                     i, tbl[i].op, tbl[i].len, tbl[i].thr, tbl[i].cap,
                     tbl[i].score, tbl[i].cnt);
            run_vec(tbl[i]);
        end

        chk("final_pending", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dice_scorer.md
# dice_scorer

Downstream consumer of the electronic dice. It shares the dice's `button` and `clk`, and watches its `throw[2:0]` output. When a valid press is released, it captures the settled throw and accumulates a score over a fixed-length game. It flags equal consecutive throws and drives an active-low seven-segment display of the last result.

## Interface
- `MAX_THROWS`, default 8: throws per game; range 1–15.
- `MIN_PRESS`, default 2: minimum cycles `button` must be sampled high for a roll to count.
- `SCORE_W`, default 6: score width; must satisfy 2^SCORE_W > 6*MAX_THROWS.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `button`  in  1  roll button; same synchronous signal that drives the dice.
- `throw`  in  3  dice output; 1–6 legal, 0/7 illegal.
- `new_game`  in  1  synchronous clear of game state.
- `result`  out  3  last captured throw.
- `result_valid`  out  1  one-cycle pulse per capture.
- `score`  out  SCORE_W  sum of legal captured throws.
- `throw_count`  out  4  number of legal captures this game.
- `double_flag`  out  1  last two legal captures were equal.
- `game_over`  out  1  `throw_count` == `MAX_THROWS`.
- `err`  out  1  sticky: an illegal throw was captured.
- `seg`  out  7  {g,f,e,d,c,b,a}, active-low, decode of `result`.

## Operation
- **FSM states:** IDLE, PRESSED, SETTLE, DONE. `press_cnt` saturates at `MIN_PRESS`.
- **IDLE:**
  - `button`=1: go to PRESSED, `press_cnt`<=1.
  - Otherwise stay.
- **PRESSED:**
  - `button`=1: `press_cnt`<=sat(+1).
  - `button`=0 and `press_cnt`>=`MIN_PRESS`: go to SETTLE.
  - `button`=0 and `press_cnt`<`MIN_PRESS`: go to IDLE. Short press, no capture.
- **SETTLE (one cycle):**
  - `result`<=`throw` and `result_valid`<=1.
  - If the throw is legal (1–6):
    - `score`+=`throw` and `throw_count`+=1.
    - `double_flag`<=(`throw_count`!=0 && `throw`==previous legal throw).
    - Previous legal throw <= `throw`.
  - If the throw is illegal (0/7): `err`<=1; `score`, `throw_count`, `double_flag` and previous legal throw are unchanged.
  - Next state is DONE if the new `throw_count` == `MAX_THROWS`, else IDLE.
- **DONE:** `game_over`=1; `button` is ignored; stays until `new_game` or `rst`.
- **`new_game`** (priority below `rst`, above all else):
  - Clears `score`, `throw_count`, `double_flag`, `err`, `game_over`, `result`, and previous legal throw.
  - Forces IDLE.
  - Valid in any state, including mid-press; the abandoned press is not captured.
- **`seg` decode:**
  - 1–6: standard digit glyphs.
  - 0 and 7: "-" (only g lit, 7'b0111111).
  - Blank is 7'h7F.
  - `seg` is blank while `throw_count`==0 and no capture has occurred since reset/`new_game`.
- **Arithmetic:** `score` is an unsigned add with no wrap possible by the parameter constraint. `throw_count` is unsigned 4-bit.

## Timing
- **Reset values** (after `rst` asserted on any edge): state IDLE, `result`=0, `result_valid`=0, `score`=0, `throw_count`=0, `double_flag`=0, `game_over`=0, `err`=0, `seg`=7'h7F.
- **Capture latency:**
  - Edge E0: first edge sampling `button`=0 after a valid press (PRESSED→SETTLE).
  - Edge E1: `throw` is sampled and registered. The dice has held `throw` stable since E0.
  - `result`, `result_valid`, `score`, `throw_count`, `double_flag`, `err`, `seg` all update at E1.
  - `result_valid` is high for exactly the cycle after E1.
  - `game_over` rises at E1 on the final throw.
- **Press counting:** a press needs ≥`MIN_PRESS` consecutive high samples. A press of exactly `MIN_PRESS` cycles is accepted.
- **Back-to-back presses:** `button`=1 sampled during SETTLE is ignored. A press must be re-sampled high in IDLE (earliest E1), so `result_valid` pulses are never adjacent.
- **`new_game` during SETTLE:** clear wins; no capture, no `result_valid`.
- **`rst` and `new_game` together:** `rst` behaviour.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- **Package `dice_pkg`:**
  - FSM state enum (`ST_IDLE`, `ST_PRESSED`, `ST_SETTLE`, `ST_DONE`).
  - Segment constants `SEG_BLANK`=7'h7F and `SEG_DASH`=7'h3F.
  - Digit glyph constants 1–6.
- **Sub-module `seg7_decoder`:** combinational 3-bit → 7-bit active-low decode with a blank input. Its output is registered in `dice_scorer`.

## Test plan
- **Basic capture:** reset, hold `button` high 5 cycles, release with `throw`=4 → one `result_valid` pulse two edges after release; `result`=4, `score`=4, `throw_count`=1, `seg`=digit-4 glyph.
- **Short press:** `MIN_PRESS`=2; press 1 cycle → no `result_valid`, state returns to IDLE. Press exactly 2 cycles → capture occurs.
- **Doubles:** captures 3, 3, 5 → `double_flag` 0, 1, 0; `score`=11.
- **Full game:** `MAX_THROWS`=8, eight captures of 6 → `score`=48, `throw_count`=8, `game_over`=1. A further press produces no `result_valid` and no change. Then `new_game` → all counters 0, `seg`=7'h7F.
- **Illegal throw:** capture with `throw`=7 → `result_valid`=1, `result`=7, `seg`=7'h3F, `err`=1, `score`/`throw_count` unchanged. `err` stays set until `new_game`.
- **Mid-operation clear:** assert `new_game` during SETTLE, and separately `rst` mid-press → no capture, outputs at reset values. The next valid press captures normally.
